note_tone_pwm: RTL
==================

Name: note_tone_pwm

Overview:
- Downstream audio stage. Consumes the game's 7-bit active-note vector (one bit per key C4..B4) and drives the board's mono PWM audio output (aud_pwm / aud_sd).
- Selects one note, synthesises it with a 32-bit phase accumulator, and shapes it with a linear attack/release envelope. The resulting 8-bit sample is delivered as 256-cycle PWM.

Parameters:
- PWM_BITS, 8, sample and PWM counter width; PWM period = 2^PWM_BITS clk cycles.
- RAMP_DIV, 1024, clk cycles per envelope step of ±1 (full ramp = 255*RAMP_DIV cycles).

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_n_in  input  1  synchronous, active-low reset.
- en_in  input  1  audio enable; 0 forces release.
- notes_in  input  7  note request; bit0=C4 … bit6=B4.
- aud_pwm  output  1  PWM audio bit.
- aud_sd  output  1  amplifier enable, 1 = amp on.
- playing_out  output  1  1 when the envelope state is not IDLE.
- note_idx_out  output  3  index of the note currently sounding; 7 = none.

Behaviour:
- Clocking: single clock clk_in. Reset is synchronous, active-low, on rst_n_in.
- Reset values: state IDLE, phase 0, increment 0, amplitude 0, ramp counter 0, pwm counter 0, sample 0, aud_pwm 0, aud_sd 0, playing_out 0, note_idx_out 7.
- Request: req = en_in & (notes_in != 0). Selected note = lowest set bit of notes_in (priority to the lower index). Registered, 1-cycle latency.
- Increment ROM (fixed, 100 MHz, inc = f*2^32/1e8): C 11237, D 12613, E 14158, F 14999, G 16836, A 18898, B 21212.
- Phase: phase <= phase + inc every cycle while state != IDLE; wraps mod 2^32. Phase is held at 0 in IDLE.
- Ramp tick: the ramp counter counts 0..RAMP_DIV-1. A tick is its terminal count. The counter runs only in ATTACK and RELEASE and is cleared on every state change.
- IDLE:
  - req → ATTACK; load inc and note_idx_out.
- ATTACK:
  - amp += 1 per tick.
  - amp reaching 255 → SUSTAIN.
  - !req → RELEASE.
- SUSTAIN:
  - amp held at 255.
  - !req → RELEASE.
- RELEASE:
  - amp -= 1 per tick.
  - A tick with amp <= 1 sets amp to 0 and goes to IDLE; note_idx_out becomes 7 and phase clears.
  - req → ATTACK, continuing from the current amp (no jump).
- Note change while req stays high (ATTACK/SUSTAIN): inc and note_idx_out update the next cycle. Phase and amp are not reset (legato, no click).
- RELEASE keeps the last increment. note_idx_out keeps the last note until IDLE.
- Sample: computed from the phase and amp (see Optional Feature). It is latched only when the pwm counter = 2^PWM_BITS-1, so each PWM period carries one constant sample.
- PWM output: aud_pwm = registered (pwm_cnt < sample). sample 0 → constant 0; sample 255 → high 255 of 256 cycles.
- aud_sd / playing_out: both = registered (state != IDLE). aud_sd and playing_out rise 1 cycle after req and fall 1 cycle after the IDLE entry.
- Simultaneous events: en_in=0 overrides notes_in. A req change and a ramp tick in the same cycle: the state transition wins, and the tick is discarded.
- Reset mid-note: all registers take their reset values on the next edge; no release tail.

Optional Feature:
- Macro: NOTE_TONE_TRIANGLE_EN.
- Defined: triangle waveform.
  - tri = phase[31] ? ~phase[30:23] : phase[30:23].
  - sample = (tri * amp) >> 8, using an 8x8 unsigned multiply with the upper 8 bits kept.
- Undefined: square waveform. sample = phase[31] ? amp : 0. No multiplier is inferred.

Test Plan:
1. Reset: rst_n_in=0 for 4 cycles with notes_in=7'h7F → aud_pwm=0, aud_sd=0, playing_out=0, note_idx_out=7 throughout.
2. RAMP_DIV=4, en_in=1, notes_in=7'b0100000 (A) → note_idx_out=5 and aud_sd=1 after 1 cycle; amp=255 and state SUSTAIN after 1020 cycles; phase increases by 18898 per cycle.
3. Priority/legato in SUSTAIN: notes_in changes 7'b0100000 → 7'b0010100 → note_idx_out=2 next cycle, inc=14158, amp stays 255, phase does not reset.
4. Release/re-attack, RAMP_DIV=4:
   - From SUSTAIN, notes_in=0 → amp falls 1 per 4 cycles.
   - notes_in=1 at amp=100 → ATTACK resumes from 100 and reaches 255 after 620 cycles.
   - A full release with no new request ends in IDLE: aud_sd=0, note_idx_out=7.
5. en_in=0 during SUSTAIN with notes_in=7'b0000001 → RELEASE. Reaches IDLE after ≈1020 cycles at RAMP_DIV=4.
6. PWM duty, square build, SUSTAIN, phase[31]=1 → aud_pwm high 255 of 256 cycles. phase[31]=0 → aud_pwm low for the whole period. The sample changes only at pwm_cnt wrap.

Source files
------------

// File: rtl/note_tone_pwm.sv
// note_tone_pwm: note select, phase accumulator, attack/release envelope, PWM out.
// Build option: define NOTE_TONE_TRIANGLE_EN for a triangle wave (default square).
module note_tone_pwm #(
  parameter int PWM_BITS = 8,
  parameter int RAMP_DIV = 1024
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       en_in,
  input  logic [6:0] notes_in,
  output logic       aud_pwm,
  output logic       aud_sd,
  output logic       playing_out,
  output logic [2:0] note_idx_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATTACK,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0] RAMP_TC = RW'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_TC = '1;

  state_t              state_q, state_d;
  logic [31:0]         phase_q, phase_d;
  logic [31:0]         inc_q, inc_d;
  logic [7:0]          amp_q, amp_d;
  logic [RW-1:0]       ramp_q, ramp_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] sample_q, sample_d;
  logic                aud_pwm_q, aud_pwm_d;
  logic                sd_q, sd_d;
  logic [2:0]          idx_q, idx_d;

  logic        req;
  logic        tick;
  logic [2:0]  sel_idx;
  logic [31:0] sel_inc;
  logic [7:0]  wave;

  assign req = en_in & (|notes_in);
  assign tick = (ramp_q == RAMP_TC) &&
                ((state_q == S_ATTACK) || (state_q == S_RELEASE));

  // Lowest set request bit wins.
  always_comb begin
    sel_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (notes_in[i]) sel_idx = 3'(i);
    end
  end

  // Phase increment ROM, inc = f * 2^32 / 100 MHz.
  always_comb begin
    case (sel_idx)
      3'd0:    sel_inc = 32'd11237;
      3'd1:    sel_inc = 32'd12613;
      3'd2:    sel_inc = 32'd14158;
      3'd3:    sel_inc = 32'd14999;
      3'd4:    sel_inc = 32'd16836;
      3'd5:    sel_inc = 32'd18898;
      3'd6:    sel_inc = 32'd21212;
      default: sel_inc = 32'd0;
    endcase
  end

`ifdef NOTE_TONE_TRIANGLE_EN
  logic [7:0]  tri_v;
  logic [15:0] prod;
  logic        unused_phase;

  assign unused_phase = ^phase_q[22:0];

  // Triangle folded from the phase top bits, scaled by the envelope.
  always_comb begin
    tri_v = phase_q[31] ? ~phase_q[30:23] : phase_q[30:23];
    prod  = 16'(tri_v) * 16'(amp_q);
    wave  = prod[15:8];
  end
`else
  logic unused_phase;

  assign unused_phase = ^phase_q[30:0];

  // Square wave: envelope level in the upper half cycle, silence otherwise.
  always_comb begin
    wave = phase_q[31] ? amp_q : 8'd0;
  end
`endif

  // Envelope FSM: next state, amplitude and note selection.
  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    inc_d   = inc_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ATTACK;
          inc_d   = sel_inc;
          idx_d   = sel_idx;
        end
      end
      S_ATTACK: begin
        if (!req) begin
          state_d = S_RELEASE;
        end else begin
          inc_d = sel_inc;
          idx_d = sel_idx;
          if (tick && (amp_q != 8'hFF)) amp_d = amp_q + 8'd1;
          if (amp_d == 8'hFF) state_d = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        amp_d = 8'hFF;
        if (!req) begin
          state_d = S_RELEASE;
        end else begin
          inc_d = sel_inc;
          idx_d = sel_idx;
        end
      end
      S_RELEASE: begin
        if (req) begin
          state_d = S_ATTACK;
          inc_d   = sel_inc;
          idx_d   = sel_idx;
        end else if (tick) begin
          if (amp_q <= 8'd1) begin
            amp_d   = 8'd0;
            state_d = S_IDLE;
            idx_d   = 3'd7;
          end else begin
            amp_d = amp_q - 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ramp divider, phase accumulator, PWM counter and output stage.
  always_comb begin
    ramp_d = '0;
    if ((state_d == state_q) &&
        ((state_q == S_ATTACK) || (state_q == S_RELEASE))) begin
      ramp_d = tick ? '0 : ramp_q + 1'b1;
    end
    if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
      phase_d = 32'd0;
    end else begin
      phase_d = phase_q + inc_q;
    end
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    sample_d  = (pwm_cnt_q == PWM_TC) ? PWM_BITS'(wave) : sample_q;
    aud_pwm_d = pwm_cnt_q < sample_q;
    sd_d      = state_d != S_IDLE;
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      inc_q     <= '0;
      amp_q     <= '0;
      ramp_q    <= '0;
      pwm_cnt_q <= '0;
      sample_q  <= '0;
      aud_pwm_q <= 1'b0;
      sd_q      <= 1'b0;
      idx_q     <= 3'd7;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      amp_q     <= amp_d;
      ramp_q    <= ramp_d;
      pwm_cnt_q <= pwm_cnt_d;
      sample_q  <= sample_d;
      aud_pwm_q <= aud_pwm_d;
      sd_q      <= sd_d;
      idx_q     <= idx_d;
    end
  end

  assign aud_pwm      = aud_pwm_q;
  assign aud_sd       = sd_q;
  assign playing_out  = sd_q;
  assign note_idx_out = idx_q;

endmodule
